// File: rtl/cam_vpipe.sv
// cam_vpipe: parametrised content-addressable memory with per-entry valid bits.
// Entries can be written through explicit write ports, allocated into the
// lowest free slot, invalidated and flushed. Each search port reports a
// registered result one cycle after the request, with a true multi-hit flag.
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_flush               clear every valid bit
//   i_we/i_waddr/i_wm/i_wd  write ports (wm bit 1 keeps the old bit)
//   i_inv/i_iaddr         invalidate ports (valid bit only, data kept)
//   i_alloc_req/i_alloc_data, o_alloc_rdy/o_alloc_addr  free-entry allocation
//   i_se/i_sm/i_sd        search enable, don't-care mask, key
//   o_s_vld/o_s_match/o_s_multi/o_s_addr  registered search results
//   o_count/o_full/o_empty  registered occupancy
module cam_vpipe #(
  parameter int DATA  = 16,
  parameter int DEPTH = 64,
  parameter int WRITE = 2,
  parameter int READ  = 4,
  parameter int INV   = 2,
  parameter int MSB   = 0,
  parameter int ADDR  = $clog2(DEPTH)
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_flush,
  input  logic [WRITE-1:0]       i_we,
  input  logic [WRITE*ADDR-1:0]  i_waddr,
  input  logic [WRITE*DATA-1:0]  i_wm,
  input  logic [WRITE*DATA-1:0]  i_wd,
  input  logic [INV-1:0]         i_inv,
  input  logic [INV*ADDR-1:0]    i_iaddr,
  input  logic                   i_alloc_req,
  input  logic [DATA-1:0]        i_alloc_data,
  output logic                   o_alloc_rdy,
  output logic [ADDR-1:0]        o_alloc_addr,
  input  logic [READ-1:0]        i_se,
  input  logic [READ*DATA-1:0]   i_sm,
  input  logic [READ*DATA-1:0]   i_sd,
  output logic [READ-1:0]        o_s_vld,
  output logic [READ-1:0]        o_s_match,
  output logic [READ-1:0]        o_s_multi,
  output logic [READ*ADDR-1:0]   o_s_addr,
  output logic [ADDR:0]          o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int CW = ADDR + 1;

  logic [DATA-1:0]      r_data [DEPTH];
  logic [DEPTH-1:0]     r_valid;
  logic [CW-1:0]        r_count;
  logic [READ-1:0]      r_s_vld;
  logic [READ-1:0]      r_s_match;
  logic [READ-1:0]      r_s_multi;
  logic [READ*ADDR-1:0] r_s_addr;

  logic [DATA-1:0]      w_data_nxt [DEPTH];
  logic [DEPTH-1:0]     w_valid_nxt;
  logic [CW-1:0]        w_count_nxt;
  logic [ADDR-1:0]      w_alloc_addr;
  logic                 w_alloc_fire;
  logic [READ-1:0]      w_match;
  logic [READ-1:0]      w_multi;
  logic [READ*ADDR-1:0] w_addr;

  assign o_full       = (r_count == CW'(DEPTH));
  assign o_empty      = (r_count == {CW{1'b0}});
  assign o_count      = r_count;
  assign o_alloc_rdy  = ~o_full;
  assign o_alloc_addr = w_alloc_addr;
  assign w_alloc_fire = i_alloc_req & o_alloc_rdy;
  assign o_s_vld      = r_s_vld;
  assign o_s_match    = r_s_match;
  assign o_s_multi    = r_s_multi;
  assign o_s_addr     = r_s_addr;

  // Lowest-index invalid entry; scanning downward leaves the lowest one.
  always_comb begin
    w_alloc_addr = {ADDR{1'b0}};
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_alloc_addr = ADDR'(i);
      end else begin
        w_alloc_addr = w_alloc_addr;
      end
    end
  end

  // Next entry state. Requests are applied lowest priority first so that
  // later assignments override: alloc, then writes (higher port wins
  // wholly), then invalidates, then flush. Masked writes merge with the
  // pre-edge entry, never with another port's data.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_data_nxt[i]  = r_data[i];
      w_valid_nxt[i] = r_valid[i];
      if (w_alloc_fire && (w_alloc_addr == ADDR'(i))) begin
        w_data_nxt[i]  = i_alloc_data;
        w_valid_nxt[i] = 1'b1;
      end else begin
        w_valid_nxt[i] = w_valid_nxt[i];
      end
      for (int p = 0; p < WRITE; p++) begin
        if (i_we[p] && (i_waddr[p*ADDR +: ADDR] == ADDR'(i))) begin
          w_data_nxt[i]  = (r_data[i] & i_wm[p*DATA +: DATA]) |
                           (i_wd[p*DATA +: DATA] & ~i_wm[p*DATA +: DATA]);
          w_valid_nxt[i] = 1'b1;
        end else begin
          w_valid_nxt[i] = w_valid_nxt[i];
        end
      end
      for (int q = 0; q < INV; q++) begin
        if (i_inv[q] && (i_iaddr[q*ADDR +: ADDR] == ADDR'(i))) begin
          w_data_nxt[i]  = r_data[i];
          w_valid_nxt[i] = 1'b0;
        end else begin
          w_valid_nxt[i] = w_valid_nxt[i];
        end
      end
      if (i_flush) begin
        w_data_nxt[i]  = r_data[i];
        w_valid_nxt[i] = 1'b0;
      end else begin
        w_valid_nxt[i] = w_valid_nxt[i];
      end
    end
  end

  // Population count of the next valid vector.
  always_comb begin
    w_count_nxt = {CW{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      w_count_nxt = w_count_nxt + {{ADDR{1'b0}}, w_valid_nxt[i]};
    end
  end

  // Search against pre-edge state. A second hit on a port raises multi;
  // the reported index is the first hit (MSB=0) or the last hit (MSB=1).
  always_comb begin
    w_match = {READ{1'b0}};
    w_multi = {READ{1'b0}};
    w_addr  = {(READ*ADDR){1'b0}};
    for (int r = 0; r < READ; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_se[r] && r_valid[i] &&
            (&(i_sm[r*DATA +: DATA] | ~(r_data[i] ^ i_sd[r*DATA +: DATA])))) begin
          if (w_match[r]) begin
            w_multi[r] = 1'b1;
          end else begin
            w_multi[r] = 1'b0;
          end
          if (!w_match[r] || (MSB != 0)) begin
            w_addr[r*ADDR +: ADDR] = ADDR'(i);
          end else begin
            w_addr[r*ADDR +: ADDR] = w_addr[r*ADDR +: ADDR];
          end
          w_match[r] = 1'b1;
        end else begin
          w_match[r] = w_match[r];
        end
      end
    end
  end

  // Storage, occupancy and registered search results.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= {DATA{1'b0}};
      end
      r_valid   <= {DEPTH{1'b0}};
      r_count   <= {CW{1'b0}};
      r_s_vld   <= {READ{1'b0}};
      r_s_match <= {READ{1'b0}};
      r_s_multi <= {READ{1'b0}};
      r_s_addr  <= {(READ*ADDR){1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= w_data_nxt[i];
      end
      r_valid   <= w_valid_nxt;
      r_count   <= w_count_nxt;
      r_s_vld   <= i_se;
      r_s_match <= w_match;
      r_s_multi <= w_multi;
      r_s_addr  <= w_addr;
    end
  end

endmodule

// File: tb/tb_cam_vpipe.sv
module tb_cam_vpipe;
  localparam int DATA = 16, DEPTH = 64, WRITE = 2, READ = 4, INV = 2, MSB = 0;
  localparam int ADDR = 6;

  logic clk = 1'b0;
  logic reset, flush, alloc_req, alloc_rdy, full, empty;
  logic [WRITE-1:0] we;
  logic [INV-1:0] inv;
  logic [READ-1:0] se, s_vld, s_match, s_multi;
  logic [DATA-1:0] alloc_data;
  logic [ADDR-1:0] alloc_addr;
  logic [ADDR:0] count;
  logic [WRITE*ADDR-1:0] waddr_f;
  logic [WRITE*DATA-1:0] wm_f, wd_f;
  logic [INV*ADDR-1:0] iaddr_f;
  logic [READ*DATA-1:0] sm_f, sd_f;
  logic [READ*ADDR-1:0] s_addr;

  logic [ADDR-1:0] t_waddr [WRITE];
  logic [DATA-1:0] t_wm [WRITE];
  logic [DATA-1:0] t_wd [WRITE];
  logic [ADDR-1:0] t_iaddr [INV];
  logic [DATA-1:0] t_sm [READ];
  logic [DATA-1:0] t_sd [READ];

  // reference model: entry contents and valid flags
  logic [DATA-1:0] m_data [DEPTH];
  bit m_valid [DEPTH];
  logic [READ-1:0] exp_vld, exp_match, exp_multi;
  logic [READ*ADDR-1:0] exp_addr;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int p = 0; p < WRITE; p++) begin
      waddr_f[p*ADDR +: ADDR] = t_waddr[p];
      wm_f[p*DATA +: DATA] = t_wm[p];
      wd_f[p*DATA +: DATA] = t_wd[p];
    end
    for (int q = 0; q < INV; q++) iaddr_f[q*ADDR +: ADDR] = t_iaddr[q];
    for (int r = 0; r < READ; r++) begin
      sm_f[r*DATA +: DATA] = t_sm[r];
      sd_f[r*DATA +: DATA] = t_sd[r];
    end
  end

  cam_vpipe #(.DATA(DATA), .DEPTH(DEPTH), .WRITE(WRITE), .READ(READ), .INV(INV), .MSB(MSB)) dut (
    .i_clk(clk), .i_reset(reset), .i_flush(flush),
    .i_we(we), .i_waddr(waddr_f), .i_wm(wm_f), .i_wd(wd_f),
    .i_inv(inv), .i_iaddr(iaddr_f),
    .i_alloc_req(alloc_req), .i_alloc_data(alloc_data),
    .o_alloc_rdy(alloc_rdy), .o_alloc_addr(alloc_addr),
    .i_se(se), .i_sm(sm_f), .i_sd(sd_f),
    .o_s_vld(s_vld), .o_s_match(s_match), .o_s_multi(s_multi), .o_s_addr(s_addr),
    .o_count(count), .o_full(full), .o_empty(empty)
  );

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(m_valid[i]);
    return n;
  endfunction

  function automatic int m_low_free();
    for (int i = 0; i < DEPTH; i++) if (!m_valid[i]) return i;
    return -1;
  endfunction

  task automatic idle();
    reset = 1'b0; flush = 1'b0; we = '0; inv = '0; se = '0;
    alloc_req = 1'b0; alloc_data = 16'h0000;
    for (int p = 0; p < WRITE; p++) begin t_waddr[p] = 6'd0; t_wm[p] = 16'h0000; t_wd[p] = 16'h0000; end
    for (int q = 0; q < INV; q++) t_iaddr[q] = 6'd0;
    for (int r = 0; r < READ; r++) begin t_sm[r] = 16'h0000; t_sd[r] = 16'h0000; end
  endtask

  // One clock: predict search results from the pre-edge model, advance the
  // model by the request rules, then wait past the edge.
  task automatic step();
    logic [DATA-1:0] nd [DEPTH];
    bit nv [DEPTH];
    int lf, hits;
    exp_vld = se; exp_match = '0; exp_multi = '0; exp_addr = '0;
    for (int r = 0; r < READ; r++) begin
      hits = 0;
      if (se[r]) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (m_valid[i] && (((m_data[i] ^ t_sd[r]) & ~t_sm[r]) == 16'h0000)) begin
            if (hits == 0 || MSB != 0) exp_addr[r*ADDR +: ADDR] = 6'(i);
            hits++;
          end
        end
      end
      exp_match[r] = (hits >= 1);
      exp_multi[r] = (hits >= 2);
    end
    nd = m_data; nv = m_valid;
    lf = m_low_free();
    if (alloc_req && lf >= 0) begin nd[lf] = alloc_data; nv[lf] = 1'b1; end
    for (int p = 0; p < WRITE; p++)
      if (we[p]) begin
        nd[t_waddr[p]] = (m_data[t_waddr[p]] & t_wm[p]) | (t_wd[p] & ~t_wm[p]);
        nv[t_waddr[p]] = 1'b1;
      end
    for (int q = 0; q < INV; q++)
      if (inv[q]) begin nd[t_iaddr[q]] = m_data[t_iaddr[q]]; nv[t_iaddr[q]] = 1'b0; end
    if (flush) for (int i = 0; i < DEPTH; i++) begin nd[i] = m_data[i]; nv[i] = 1'b0; end
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin nd[i] = 16'h0000; nv[i] = 1'b0; end
      exp_vld = '0; exp_match = '0; exp_multi = '0; exp_addr = '0;
    end
    @(posedge clk); #1;
    m_data = nd; m_valid = nv;
  endtask

  task automatic test_reset();
    idle(); reset = 1'b1; step(); idle();
    total++; if (count !== 7'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if ({empty, full, alloc_rdy} !== 3'b101) begin bad++; $display("FAIL reset_flags got=%b exp=101", {empty, full, alloc_rdy}); end
    total++; if (alloc_addr !== 6'd0) begin bad++; $display("FAIL reset_alloc_addr got=%0d exp=0", alloc_addr); end
    total++; if ({s_vld, s_match, s_multi, s_addr} !== 36'h0) begin bad++; $display("FAIL reset_search got=%0h exp=0", {s_vld, s_match, s_multi, s_addr}); end
  endtask

  task automatic test_alloc();
    for (int k = 0; k < 3; k++) begin
      total++; if (alloc_addr !== 6'(k)) begin bad++; $display("FAIL alloc_addr got=%0d exp=%0d", alloc_addr, k); end
      alloc_req = 1'b1; alloc_data = 16'h000A + 16'(k); step();
    end
    idle();
    total++; if (count !== 7'd3) begin bad++; $display("FAIL alloc_count got=%0d exp=3", count); end
    se[0] = 1'b1; t_sd[0] = 16'h000B; step(); idle();
    total++; if ({s_vld[0], s_match[0], s_multi[0], s_addr[5:0]} !== {3'b110, 6'd1}) begin
      bad++; $display("FAIL alloc_search got=%b%b%b/%0d exp=110/1", s_vld[0], s_match[0], s_multi[0], s_addr[5:0]); end
  endtask

  task automatic test_write_multi();
    we = 2'b11; t_waddr[0] = 6'd5; t_waddr[1] = 6'd7; t_wd[0] = 16'h1234; t_wd[1] = 16'h1234; step(); idle();
    se[0] = 1'b1; t_sd[0] = 16'h12FF; t_sm[0] = 16'h00FF; step(); idle();
    total++; if ({s_match[0], s_multi[0], s_addr[5:0]} !== {2'b11, (MSB != 0) ? 6'd7 : 6'd5}) begin
      bad++; $display("FAIL write_multi got=%b%b/%0d exp=11/%0d", s_match[0], s_multi[0], s_addr[5:0], (MSB != 0) ? 7 : 5); end
  endtask

  task automatic test_inv_search();
    inv[0] = 1'b1; t_iaddr[0] = 6'd5; se[0] = 1'b1; t_sd[0] = 16'h1234; step(); idle();
    total++; if ({s_match[0], s_multi[0], s_addr[5:0]} !== {2'b11, (MSB != 0) ? 6'd7 : 6'd5}) begin
      bad++; $display("FAIL inv_same_cycle got=%b%b/%0d", s_match[0], s_multi[0], s_addr[5:0]); end
    se[0] = 1'b1; t_sd[0] = 16'h1234; step(); idle();
    total++; if ({s_match[0], s_multi[0], s_addr[5:0]} !== {2'b10, 6'd7}) begin
      bad++; $display("FAIL inv_next_cycle got=%b%b/%0d exp=10/7", s_match[0], s_multi[0], s_addr[5:0]); end
  endtask

  task automatic test_full();
    int guard = 0;
    while (alloc_rdy === 1'b1 && guard < 100) begin
      alloc_req = 1'b1; alloc_data = 16'h5000 + 16'(guard); step(); guard++;
    end
    idle();
    total++; if (guard >= 100) begin bad++; $display("FAIL full_timeout got=%0d exp=<100 allocs", guard); end
    total++; if ({full, alloc_rdy, count} !== {2'b10, 7'd64}) begin
      bad++; $display("FAIL full_state got=%b%b/%0d exp=10/64", full, alloc_rdy, count); end
    alloc_req = 1'b1; alloc_data = 16'hDEAD; step(); idle();
    total++; if (count !== 7'd64) begin bad++; $display("FAIL full_extra_alloc got=%0d exp=64", count); end
    inv[1] = 1'b1; t_iaddr[1] = 6'd9; step(); idle();
    total++; if ({alloc_addr, count} !== {6'd9, 7'd63}) begin
      bad++; $display("FAIL full_inv9 got=%0d/%0d exp=9/63", alloc_addr, count); end
  endtask

  task automatic test_write_conflict();
    we = 2'b11; t_waddr[0] = 6'd3; t_waddr[1] = 6'd3; t_wd[0] = 16'h00FF; t_wd[1] = 16'hFF00; step(); idle();
    se = 4'b0110; t_sd[1] = 16'hFF00; t_sd[2] = 16'h00FF; step(); idle();
    total++; if ({s_match[2:1], s_multi[1], s_addr[11:6]} !== {3'b010, 6'd3}) begin
      bad++; $display("FAIL wr_conflict got=%b%b/%0d exp=010/3", s_match[2:1], s_multi[1], s_addr[11:6]); end
    inv[1] = 1'b1; t_iaddr[1] = 6'd3; we[0] = 1'b1; t_waddr[0] = 6'd3; t_wd[0] = 16'h1111; step(); idle();
    se = 4'b0110; t_sd[1] = 16'hFF00; t_sd[2] = 16'h1111; step(); idle();
    total++; if (s_match[2:1] !== 2'b00) begin bad++; $display("FAIL inv_over_we got=%b exp=00", s_match[2:1]); end
    total++; if ({alloc_addr, count} !== {6'd3, 7'd62}) begin bad++; $display("FAIL inv_over_we_cnt got=%0d/%0d exp=3/62", alloc_addr, count); end
  endtask

  task automatic test_flush();
    flush = 1'b1; alloc_req = 1'b1; we[0] = 1'b1; t_waddr[0] = 6'd20; t_wd[0] = 16'h7777;
    se = 4'hF; for (int r = 0; r < READ; r++) t_sm[r] = 16'hFFFF;
    step(); idle();
    total++; if (s_match !== 4'hF) begin bad++; $display("FAIL flush_preflush_search got=%b exp=1111", s_match); end
    total++; if ({count, empty, alloc_addr} !== {7'd0, 1'b1, 6'd0}) begin
      bad++; $display("FAIL flush_state got=%0d/%b/%0d exp=0/1/0", count, empty, alloc_addr); end
    se = 4'hF; for (int r = 0; r < READ; r++) t_sm[r] = 16'hFFFF; step(); idle();
    total++; if ({s_vld, s_match} !== 8'hF0) begin bad++; $display("FAIL flush_search got=%h exp=f0", {s_vld, s_match}); end
    alloc_req = 1'b1; alloc_data = 16'h0042; step(); idle();
    se = 4'hF; t_sd[0] = 16'h0042; reset = 1'b1; step(); idle();
    total++; if ({s_vld, s_match, count} !== {8'h00, 7'd0}) begin
      bad++; $display("FAIL reset_mid_search got=%h/%0d exp=00/0", {s_vld, s_match}, count); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      idle();
      reset = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 39) == 0);
      for (int p = 0; p < WRITE; p++) begin
        we[p] = ($urandom_range(0, 2) == 0);
        t_waddr[p] = 6'($urandom_range(0, 15));
        t_wm[p] = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'($urandom);
        t_wd[p] = 16'($urandom_range(0, 7));
      end
      for (int q = 0; q < INV; q++) begin
        inv[q] = ($urandom_range(0, 3) == 0);
        t_iaddr[q] = 6'($urandom_range(0, 15));
      end
      alloc_req = ($urandom_range(0, 2) == 0);
      alloc_data = 16'($urandom_range(0, 7));
      se = 4'($urandom);
      for (int r = 0; r < READ; r++) begin
        t_sd[r] = 16'($urandom_range(0, 7));
        case ($urandom_range(0, 3))
          0: t_sm[r] = 16'hFFFF;
          1: t_sm[r] = 16'h0003;
          default: t_sm[r] = 16'h0000;
        endcase
      end
      step();
      total++; if ({s_vld, s_match, s_multi} !== {exp_vld, exp_match, exp_multi}) begin
        bad++; $display("FAIL rnd_flags c=%0d got=%h exp=%h", c, {s_vld, s_match, s_multi}, {exp_vld, exp_match, exp_multi}); end
      total++; if (s_addr !== exp_addr) begin bad++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, s_addr, exp_addr); end
      total++; if (count !== 7'(m_count())) begin bad++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, count, m_count()); end
      total++; if ({full, empty, alloc_rdy} !== {m_count() == DEPTH, m_count() == 0, m_count() != DEPTH}) begin
        bad++; $display("FAIL rnd_occ c=%0d got=%b cnt=%0d", c, {full, empty, alloc_rdy}, m_count()); end
      total++; if (alloc_addr !== 6'((m_low_free() < 0) ? 0 : m_low_free())) begin
        bad++; $display("FAIL rnd_alloc_addr c=%0d got=%0d exp=%0d", c, alloc_addr, m_low_free()); end
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin m_data[i] = 16'h0000; m_valid[i] = 1'b0; end
    idle();
    @(negedge clk);
    test_reset();
    test_alloc();
    test_write_multi();
    test_inv_search();
    test_full();
    test_write_conflict();
    test_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
